// File: rtl/rsa_block_framer_if.sv
// rsa_block_framer_if
//   Bundles every non-clock signal of the RSA block framer.
//   Host byte input  : n, in_valid, in_data, in_last, in_ready
//   Encryptor launch : enc_rst, enc_message, enc_done, enc_cipher
//   Ciphertext out   : out_valid, out_data, out_last, out_ready
//   Status           : err_range, err_timeout, busy
//   Optional macro RSA_BLK_STATS_EN adds blk_count / drop_count.
//   Modports: slave = framer side, master = host/encryptor/sink side.
interface rsa_block_framer_if;
  logic [127:0] n;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_ready;
  logic         enc_rst;
  logic [127:0] enc_message;
  logic         enc_done;
  logic [127:0] enc_cipher;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
  logic         out_ready;
  logic         err_range;
  logic         err_timeout;
  logic         busy;
`ifdef RSA_BLK_STATS_EN
  logic [15:0]  blk_count;
  logic [15:0]  drop_count;
`endif

  modport slave (
    input  n, in_valid, in_data, in_last, enc_done, enc_cipher, out_ready,
    output in_ready, enc_rst, enc_message, out_valid, out_data, out_last,
           err_range, err_timeout, busy
`ifdef RSA_BLK_STATS_EN
    , output blk_count, drop_count
`endif
  );

  modport master (
    output n, in_valid, in_data, in_last, enc_done, enc_cipher, out_ready,
    input  in_ready, enc_rst, enc_message, out_valid, out_data, out_last,
           err_range, err_timeout, busy
`ifdef RSA_BLK_STATS_EN
    , input blk_count, drop_count
`endif
  );
endinterface

// File: rtl/rsa_block_framer.sv
// rsa_block_framer
//   Packs a host byte stream into 128-bit blocks (first byte -> bits
//   [127:120], short blocks zero-padded), range-checks each block against
//   modulus n, launches the encryptor with a one-cycle enc_rst pulse, waits
//   for a rising edge on enc_done (bounded by TIMEOUT_CYCLES) and streams the
//   ciphertext back out MSB byte first. Input is back-pressured for the whole
//   encrypt + unload so blocks never overlap.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - rsa_block_framer_if.slave (host in, encryptor, ciphertext out,
//           err_range / err_timeout pulses, busy)
// Parameters: BLOCK_BYTES (16), TIMEOUT_CYCLES (65535)
// Optional feature: define RSA_BLK_STATS_EN for saturating blk_count /
//   drop_count statistics outputs.
module rsa_block_framer #(
  parameter int BLOCK_BYTES    = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  rsa_block_framer_if.slave bus
);
  localparam int W  = BLOCK_BYTES * 8;
  localparam int CW = $clog2(BLOCK_BYTES);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(BLOCK_BYTES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [W-1:0]  N_MIN      = W'(2);

  typedef enum logic [2:0] {LOAD, CHECK, KICK, WAIT, UNLOAD} state_t;

  state_t        state;
  logic [W-1:0]  msg;
  logic [W-1:0]  cbuf;
  logic [W-1:0]  enc_msg;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ocnt;
  logic [TW-1:0] timer;
  logic          done_q;
  logic          err_range_q;
  logic          err_timeout_q;

  logic          in_fire;
  logic          unload;
  logic          done_edge;
  logic [W-1:0]  msg_shift;
  logic [CW+2:0] pad_sh;

  assign in_fire   = bus.in_valid & (state == LOAD);
  assign unload    = (state == UNLOAD);
  assign done_edge = bus.enc_done & ~done_q;
  assign msg_shift = {msg[W-9:0], bus.in_data};
  // Bytes still missing after the current one, times 8: pads a short block
  // in a single shift and also flushes any bits left from the previous block.
  assign pad_sh    = {CNT_LAST - cnt, 3'b000};

  // Framer FSM: byte packing, range check, launch, wait and unload.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LOAD;
      msg           <= '0;
      cbuf          <= '0;
      enc_msg       <= '0;
      cnt           <= '0;
      ocnt          <= '0;
      timer         <= '0;
      done_q        <= 1'b0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      // done_q also samples during KICK, so a done level still high from the
      // previous run is seen as "already high" and never counts as an edge.
      done_q        <= bus.enc_done;
      case (state)
        LOAD: begin
          if (in_fire) begin
            if ((cnt == CNT_LAST) || bus.in_last) begin
              msg   <= msg_shift << pad_sh;
              cnt   <= '0;
              state <= CHECK;
            end else begin
              msg <= msg_shift;
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        CHECK: begin
          if ((bus.n < N_MIN) || (msg >= bus.n)) begin
            err_range_q <= 1'b1;
            state       <= LOAD;
          end else begin
            enc_msg <= msg;
            state   <= KICK;
          end
        end
        KICK: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Edge is tested first so it wins over a coincident timeout.
          if (done_edge) begin
            cbuf  <= bus.enc_cipher;
            ocnt  <= '0;
            state <= UNLOAD;
          end else if (timer == TIMER_LAST) begin
            err_timeout_q <= 1'b1;
            state         <= LOAD;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        UNLOAD: begin
          if (bus.out_ready) begin
            cbuf <= cbuf << 8;
            ocnt <= ocnt + CNT_ONE;
            if (ocnt == CNT_LAST) begin
              state <= LOAD;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Outputs are decoded from registers; reset forces them quiet immediately.
  assign bus.in_ready    = ~reset & (state == LOAD);
  assign bus.enc_rst     = reset | (state == KICK);
  assign bus.enc_message = reset ? '0 : enc_msg;
  assign bus.out_valid   = ~reset & unload;
  assign bus.out_data    = (~reset & unload) ? cbuf[W-1 -: 8] : 8'h00;
  assign bus.out_last    = ~reset & unload & (ocnt == CNT_LAST);
  assign bus.err_range   = ~reset & err_range_q;
  assign bus.err_timeout = ~reset & err_timeout_q;
  assign bus.busy        = ~reset & (state != LOAD);

`ifdef RSA_BLK_STATS_EN
  logic [15:0] blk_cnt;
  logic [15:0] drop_cnt;

  // Saturating counters of completed and dropped blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt  <= 16'h0000;
      drop_cnt <= 16'h0000;
    end else begin
      if (unload && bus.out_ready && (ocnt == CNT_LAST) && (blk_cnt != 16'hFFFF)) begin
        blk_cnt <= blk_cnt + 16'h0001;
      end
      if ((err_range_q || err_timeout_q) && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'h0001;
      end
    end
  end

  assign bus.blk_count  = blk_cnt;
  assign bus.drop_count = drop_cnt;
`endif
endmodule

// File: tb/tb_rsa_block_framer.sv
// tb_rsa_block_framer
//   Directed bench for rsa_block_framer. u_dut (long timeout) is driven with
//   a mock encryptor of programmable latency; u_dut_to (TIMEOUT_CYCLES=100)
//   sees enc_done stuck high and is used for the timeout case.
module tb_rsa_block_framer;
  localparam int TO_MAIN  = 1000;
  localparam int TO_SHORT = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rsa_block_framer_if bus();
  rsa_block_framer_if bus_to();

  rsa_block_framer #(.BLOCK_BYTES(16), .TIMEOUT_CYCLES(TO_MAIN)) u_dut (
    .clk(clk), .reset(reset), .bus(bus));
  rsa_block_framer #(.BLOCK_BYTES(16), .TIMEOUT_CYCLES(TO_SHORT)) u_dut_to (
    .clk(clk), .reset(reset), .bus(bus_to));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Mock encryptor: enc_rst restarts it, done rises mock_lat cycles later.
  int           mock_lat = 10;
  logic [127:0] mock_cipher = '0;
  int           m_cnt;
  logic         m_busy;
  always @(posedge clk) begin
    if (bus.enc_rst) begin
      m_busy         <= 1'b1;
      m_cnt          <= mock_lat;
      bus.enc_done   <= 1'b0;
      bus.enc_cipher <= '0;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy         <= 1'b0;
        bus.enc_done   <= 1'b1;
        bus.enc_cipher <= mock_cipher;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Output monitor: records handshaked bytes and counts protocol events.
  logic [7:0] ob_q[$];
  logic       ol_q[$];
  int         kick_cycles = 0;
  int         er_cnt = 0;
  int         stall_bad = 0;
  int         overlap = 0;
  logic       prev_v, prev_r, prev_l;
  logic [7:0] prev_d;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        ob_q.push_back(bus.out_data);
        ol_q.push_back(bus.out_last);
      end
      if (bus.enc_rst) kick_cycles <= kick_cycles + 1;
      if (bus.err_range) er_cnt <= er_cnt + 1;
      if (bus.in_ready && bus.busy) overlap <= overlap + 1;
      if (prev_v && !prev_r &&
          (!bus.out_valid || bus.out_data !== prev_d || bus.out_last !== prev_l))
        stall_bad <= stall_bad + 1;
    end
    prev_v <= !reset && bus.out_valid;
    prev_r <= bus.out_ready;
    prev_d <= bus.out_data;
    prev_l <= bus.out_last;
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Send nb bytes of blk (MSB byte first), in_last on the final byte if last.
  task automatic send_block(input logic [127:0] blk, input int nb, input bit last);
    int guard;
    @(posedge clk);
    #1;
    for (int i = 0; i < nb; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = blk[127-8*i -: 8];
      bus.in_last  = last && (i == nb - 1);
      guard = 0;
      sample();
      while (!bus.in_ready && guard < 2000) begin
        sample();
        guard++;
      end
      if (guard >= 2000) check_eq("send_bound", 128'd0, 128'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Called right after the last byte was accepted (state CHECK).
  task automatic expect_check(input string tag, input bit bad);
    sample();
    check_eq({tag, "_check_ready"}, bus.in_ready, 1'b0);
    sample();
    check_eq({tag, "_err_range"}, bus.err_range, bad);
    check_eq({tag, "_enc_rst"}, bus.enc_rst, !bad);
    check_eq({tag, "_in_ready"}, bus.in_ready, bad);
  endtask

  // Collect one 16-byte block, out_ready following pat cyclically.
  task automatic collect(input logic [3:0] pat, output logic [127:0] word, output logic [15:0] lmask);
    int base;
    int k;
    base = ob_q.size();
    k = 0;
    word = '0;
    lmask = '0;
    bus.out_ready = pat[0];
    while (ob_q.size() < base + 16 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
      bus.out_ready = pat[k % 4];
      sample();
    end
    check_eq("collect_bound", ob_q.size() >= base + 16, 1'b1);
    if (ob_q.size() >= base + 16) begin
      for (int i = 0; i < 16; i++) begin
        word     = {word[119:0], ob_q[base+i]};
        lmask[i] = ol_q[base+i];
      end
    end
  endtask

  logic [127:0] word;
  logic [15:0]  lmask;
  logic [127:0] rblk;
  logic [127:0] c3;
  logic [39:0]  got5;
  int k0, e0, s0, base, g, c, ov, exp_blk, exp_drop;

  initial begin
    reset = 1'b1;
    bus.n = 128'd3233;  bus.in_valid = 1'b0; bus.in_data = 8'h00;
    bus.in_last = 1'b0; bus.out_ready = 1'b1;
    bus_to.n = 128'd3233; bus_to.in_valid = 1'b0; bus_to.in_data = 8'h00;
    bus_to.in_last = 1'b0; bus_to.out_ready = 1'b1;
    bus_to.enc_done = 1'b1; bus_to.enc_cipher = '0;
    exp_blk = 0; exp_drop = 0;

    // Reset state
    sample();
    check_eq("rst_in_ready", bus.in_ready, 1'b0);
    check_eq("rst_enc_rst", bus.enc_rst, 1'b1);
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_enc_message", bus.enc_message, 128'd0);
    check_eq("rst_errs", {bus.err_range, bus.err_timeout}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;
    sample();
    check_eq("idle_in_ready", bus.in_ready, 1'b1);
    check_eq("idle_enc_rst", bus.enc_rst, 1'b0);

    // Basic block: 65 under n=3233, cipher 2790 after 200 cycles
    mock_lat = 200; mock_cipher = 128'd2790;
    k0 = kick_cycles;
    send_block(128'd65, 16, 1'b1);
    expect_check("basic", 1'b0);
    check_eq("basic_enc_message", bus.enc_message, 128'd65);
    collect(4'b1111, word, lmask);
    check_eq("basic_cipher_bytes", word, 128'd2790);
    check_eq("basic_out_last", lmask, 16'h8000);
    check_eq("basic_kick_cycles", kick_cycles - k0, 1);
    exp_blk++;

    // Short block 0x12,0x34 under n=2^127 -> padded, encrypted
    bus.n = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    mock_lat = 20; mock_cipher = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    send_block(128'h1234_0000_0000_0000_0000_0000_0000_0000, 2, 1'b1);
    expect_check("short", 1'b0);
    check_eq("short_enc_message", bus.enc_message, 128'h1234_0000_0000_0000_0000_0000_0000_0000);
    collect(4'b1111, word, lmask);
    check_eq("short_cipher_bytes", word, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
    exp_blk++;

    // Short block 0x90,0xAB is >= 2^127 -> dropped
    k0 = kick_cycles; e0 = er_cnt;
    send_block(128'h90AB_0000_0000_0000_0000_0000_0000_0000, 2, 1'b1);
    expect_check("short_big", 1'b1);
    sample();
    check_eq("short_big_err_once", er_cnt - e0, 1);
    check_eq("short_big_no_kick", kick_cycles - k0, 0);
    exp_drop++;

    // Range boundaries
    rblk = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bus.n = 128'd1;
    send_block(128'd0, 16, 1'b0);
    expect_check("range_n1", 1'b1);
    exp_drop++;
    bus.n = rblk;
    send_block(rblk, 16, 1'b0);
    expect_check("range_eq", 1'b1);
    exp_drop++;
    bus.n = rblk + 128'd1;
    mock_cipher = 128'hCAFE_F00D_0000_0000_1111_2222_3333_4444;
    send_block(rblk, 16, 1'b0);
    expect_check("range_ok", 1'b0);
    check_eq("range_ok_enc_message", bus.enc_message, rblk);
    collect(4'b1111, word, lmask);
    check_eq("range_ok_cipher", word, 128'hCAFE_F00D_0000_0000_1111_2222_3333_4444);
    exp_blk++;

    // Timeout on u_dut_to: enc_done stuck high, TIMEOUT_CYCLES=100
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      bus_to.in_valid = 1'b1;
      bus_to.in_data  = (i == 15) ? 8'h41 : 8'h00;
      bus_to.in_last  = (i == 15);
      @(posedge clk); #1;
    end
    bus_to.in_valid = 1'b0; bus_to.in_last = 1'b0;
    g = 0;
    sample();
    while (!bus_to.enc_rst && g < 10) begin sample(); g++; end
    check_eq("to_kick_seen", bus_to.enc_rst, 1'b1);
    c = 0; ov = 0;
    do begin
      sample();
      c++;
      if (bus_to.out_valid) ov++;
    end while (!bus_to.err_timeout && c < 400);
    // WAIT cycles 1..100, pulse registered into the following LOAD cycle
    check_eq("to_pulse_cycle", c, TO_SHORT + 1);
    check_eq("to_no_out_valid", ov, 0);
    check_eq("to_back_in_load", {bus_to.busy, bus_to.in_ready}, 2'b01);
    sample();
    check_eq("to_single_pulse", bus_to.err_timeout, 1'b0);

    // Backpressure: out_ready 1,0,0,1
    bus.n = 128'd3233;
    mock_cipher = 128'hA1B2_C3D4_E5F6_0718_293A_4B5C_6D7E_8F90;
    s0 = stall_bad;
    send_block(128'd1000, 16, 1'b1);
    expect_check("bp", 1'b0);
    collect(4'b1001, word, lmask);
    check_eq("bp_cipher_bytes", word, 128'hA1B2_C3D4_E5F6_0718_293A_4B5C_6D7E_8F90);
    check_eq("bp_out_last", lmask, 16'h8000);
    check_eq("bp_stall_stable", stall_bad - s0, 0);
    check_eq("bp_in_ready_before_final", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    sample();
    check_eq("bp_in_ready_after_final", bus.in_ready, 1'b1);
    check_eq("bp_out_valid_drop", bus.out_valid, 1'b0);
    check_eq("no_in_out_overlap", overlap, 0);
    exp_blk++;
`ifdef RSA_BLK_STATS_EN
    check_eq("stats_blk_count", bus.blk_count, exp_blk);
    check_eq("stats_drop_count", bus.drop_count, exp_drop);
`endif

    // Reset mid-UNLOAD after 5 bytes
    c3 = 128'h5566_7788_99AA_BBCC_DDEE_FF00_1122_3344;
    mock_cipher = c3;
    send_block(128'd7, 16, 1'b1);
    expect_check("mid", 1'b0);
    base = ob_q.size(); g = 0;
    bus.out_ready = 1'b1;
    while (ob_q.size() < base + 5 && g < 2000) begin sample(); g++; end
    check_eq("mid_reach5", ob_q.size() >= base + 5, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; bus.out_ready = 1'b0;
    sample();
    check_eq("mid_rst_out_valid", bus.out_valid, 1'b0);
    check_eq("mid_rst_enc_rst", bus.enc_rst, 1'b1);
    check_eq("mid_rst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    sample();
    check_eq("mid_post_out_valid", bus.out_valid, 1'b0);
    check_eq("mid_post_in_ready", bus.in_ready, 1'b1);
    check_eq("mid_bytes_sent", ob_q.size() - base, 5);
    got5 = '0;
    for (int i = 0; i < 5 && base + i < ob_q.size(); i++) got5 = {got5[31:0], ob_q[base+i]};
    check_eq("mid_first5", got5, c3[127:88]);
`ifdef RSA_BLK_STATS_EN
    check_eq("mid_stats_cleared", {bus.blk_count, bus.drop_count}, 32'd0);
`endif
    bus.out_ready = 1'b1;
    mock_cipher = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    send_block(128'd9, 16, 1'b1);
    expect_check("post", 1'b0);
    collect(4'b1111, word, lmask);
    check_eq("post_cipher_from_byte0", word, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0);
    check_eq("post_out_last", lmask, 16'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
